// File: rtl/acc_ctrl_pkg.sv
// Shared encodings for the accumulator machine control unit.
package acc_ctrl_pkg;

    localparam int unsigned OPW = 4;
    localparam int unsigned SW  = 4;

    localparam logic [OPW-1:0] OpHalt  = 4'h0;
    localparam logic [OPW-1:0] OpLoad  = 4'h1;
    localparam logic [OPW-1:0] OpStore = 4'h2;
    localparam logic [OPW-1:0] OpAdd   = 4'h3;
    localparam logic [OPW-1:0] OpSub   = 4'h4;
    localparam logic [OPW-1:0] OpAnd   = 4'h5;
    localparam logic [OPW-1:0] OpOr    = 4'h6;
    localparam logic [OPW-1:0] OpAddi  = 4'h7;
    localparam logic [OPW-1:0] OpBeq   = 4'h8;
    localparam logic [OPW-1:0] OpBne   = 4'h9;
    localparam logic [OPW-1:0] OpJump  = 4'hA;
    localparam logic [OPW-1:0] OpAddsp = 4'hB;

    typedef enum logic [SW-1:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StAddr   = 4'd2,
        StMemrd  = 4'd3,
        StAccwb  = 4'd4,
        StMemwr  = 4'd5,
        StAcci   = 4'd6,
        StBr     = 4'd7,
        StJmp    = 4'd8,
        StSpadd  = 4'd9,
        StHalt   = 4'd10
    } state_e;

    typedef enum logic [1:0] {
        PcSrcAlu    = 2'd0,
        PcSrcZe     = 2'd1,
        PcSrcAluOut = 2'd2
    } pc_src_e;

    typedef enum logic [1:0] {
        MemAddrPc     = 2'd0,
        MemAddrSeLeft = 2'd1,
        MemAddrAluOut = 2'd2
    } mem_addr_e;

    typedef enum logic {
        MemDataAcc    = 1'b0,
        MemDataAluOut = 1'b1
    } mem_data_e;

    typedef enum logic [1:0] {
        SrcAPc  = 2'd0,
        SrcAAcc = 2'd1,
        SrcASp  = 2'd2
    } src_a_e;

    typedef enum logic [2:0] {
        SrcBMdr = 3'd0,
        SrcBSe  = 3'd1,
        SrcBZe  = 3'd2,
        SrcBSl1 = 3'd3,
        SrcBTwo = 3'd4
    } src_b_e;

    typedef enum logic [2:0] {
        AluAdd   = 3'd0,
        AluSub   = 3'd1,
        AluAnd   = 3'd2,
        AluOr    = 3'd3,
        AluPassB = 3'd4,
        AluPassA = 3'd5
    } alu_op_e;

    typedef struct packed {
        logic      ir_write;
        logic      pc_write;
        logic      branch;
        logic      bne_or_beq;
        pc_src_e   pc_src;
        mem_addr_e mem_addr;
        mem_data_e mem_data;
        logic      mem_write;
        logic      acc_write;
        logic      sp_write;
        src_a_e    alu_src_a;
        src_b_e    alu_src_b;
        alu_op_e   alu_op;
        logic      halted;
    } ctrl_t;

endpackage

// File: rtl/acc_ctrl_outputs.sv
// Moore output decode: (state, latched opcode) -> datapath control vector.
module acc_ctrl_outputs
    import acc_ctrl_pkg::*;
(
    input  logic           reset_i,
    input  state_e         state_i,
    input  logic [OPW-1:0] op_i,
    output ctrl_t          ctrl_o,
    output logic [SW-1:0]  state_o
);

    // Per-state control values; everything is forced low while reset is held.
    always_comb begin
        ctrl_o  = '0;
        state_o = state_i;
        if (reset_i) begin
            state_o = '0;
        end else begin
            case (state_i)
                StFetch: begin
                    ctrl_o.mem_addr  = MemAddrPc;
                    ctrl_o.alu_src_a = SrcAPc;
                    ctrl_o.alu_src_b = SrcBTwo;
                    ctrl_o.alu_op    = AluAdd;
                    ctrl_o.pc_src    = PcSrcAlu;
                    ctrl_o.pc_write  = 1'b1;
                end
                StDecode: ctrl_o.ir_write = 1'b1;
                StAddr: begin
                    ctrl_o.alu_src_b = SrcBZe;
                    ctrl_o.alu_op    = AluPassB;
                end
                StMemrd: ctrl_o.mem_addr = MemAddrAluOut;
                StAccwb: begin
                    ctrl_o.alu_src_a = SrcAAcc;
                    ctrl_o.alu_src_b = SrcBMdr;
                    ctrl_o.acc_write = 1'b1;
                    case (op_i)
                        OpAdd:   ctrl_o.alu_op = AluAdd;
                        OpSub:   ctrl_o.alu_op = AluSub;
                        OpAnd:   ctrl_o.alu_op = AluAnd;
                        OpOr:    ctrl_o.alu_op = AluOr;
                        default: ctrl_o.alu_op = AluPassB;
                    endcase
                end
                StMemwr: begin
                    ctrl_o.mem_addr  = MemAddrAluOut;
                    ctrl_o.mem_data  = MemDataAcc;
                    ctrl_o.mem_write = 1'b1;
                end
                StAcci: begin
                    ctrl_o.alu_src_a = SrcAAcc;
                    ctrl_o.alu_src_b = SrcBSe;
                    ctrl_o.alu_op    = AluAdd;
                    ctrl_o.acc_write = 1'b1;
                end
                StBr: begin
                    // Taken/not-taken is resolved by the PC unit from Zero.
                    ctrl_o.alu_src_a  = SrcAAcc;
                    ctrl_o.alu_op     = AluPassA;
                    ctrl_o.branch     = 1'b1;
                    ctrl_o.bne_or_beq = op_i[0];
                    ctrl_o.pc_src     = PcSrcZe;
                end
                StJmp: begin
                    ctrl_o.pc_src   = PcSrcZe;
                    ctrl_o.pc_write = 1'b1;
                end
                StSpadd: begin
                    ctrl_o.alu_src_a = SrcASp;
                    ctrl_o.alu_src_b = SrcBSe;
                    ctrl_o.alu_op    = AluAdd;
                    ctrl_o.sp_write  = 1'b1;
                end
                StHalt:  ctrl_o.halted = 1'b1;
                default: ctrl_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/accumulator_control.sv
// Multicycle control FSM for the accumulator datapath.
module accumulator_control
    import acc_ctrl_pkg::*;
(
    input  logic          CLK,
    input  logic          reset,
    input  logic [15:0]   Instr,
    input  logic          Zero,
    output logic          IRWrite,
    output logic          PCWrite,
    output logic          Branch,
    output logic          bneOrbeq,
    output logic [1:0]    PCSrc,
    output logic [1:0]    MemAddr,
    output logic          MemData,
    output logic          MemWrite,
    output logic          AccWrite,
    output logic          SpWrite,
    output logic [1:0]    ALUSrcA,
    output logic [2:0]    ALUSrcB,
    output logic [2:0]    ALUOp,
    output logic          halted,
    output logic [SW-1:0] state
);

    state_e         state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    ctrl_t          ctrl;

    // Zero goes straight to the PC unit; only the opcode field of Instr matters here.
    logic unused_inputs;
    assign unused_inputs = ^{Zero, Instr[11:0]};

    // Next-state selection; the opcode is captured while in DECODE.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            StFetch: state_d = StDecode;
            StDecode: begin
                op_d = Instr[15:12];
                case (Instr[15:12])
                    OpHalt:                                     state_d = StHalt;
                    OpLoad, OpStore, OpAdd, OpSub, OpAnd, OpOr: state_d = StAddr;
                    OpAddi:                                     state_d = StAcci;
                    OpBeq, OpBne:                               state_d = StBr;
                    OpJump:                                     state_d = StJmp;
                    OpAddsp:                                    state_d = StSpadd;
                    default:                                    state_d = StFetch;
                endcase
            end
            StAddr:  state_d = (op_q == OpStore) ? StMemwr : StMemrd;
            StMemrd: state_d = StAccwb;
            StAccwb, StMemwr, StAcci, StBr, StJmp, StSpadd: state_d = StFetch;
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    // State and opcode registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= StFetch;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    acc_ctrl_outputs u_outputs (
        .reset_i (reset),
        .state_i (state_q),
        .op_i    (op_q),
        .ctrl_o  (ctrl),
        .state_o (state)
    );

    assign IRWrite  = ctrl.ir_write;
    assign PCWrite  = ctrl.pc_write;
    assign Branch   = ctrl.branch;
    assign bneOrbeq = ctrl.bne_or_beq;
    assign PCSrc    = ctrl.pc_src;
    assign MemAddr  = ctrl.mem_addr;
    assign MemData  = ctrl.mem_data;
    assign MemWrite = ctrl.mem_write;
    assign AccWrite = ctrl.acc_write;
    assign SpWrite  = ctrl.sp_write;
    assign ALUSrcA  = ctrl.alu_src_a;
    assign ALUSrcB  = ctrl.alu_src_b;
    assign ALUOp    = ctrl.alu_op;
    assign halted   = ctrl.halted;

endmodule

// File: tb/tb_accumulator_control.sv
// Self-checking bench for accumulator_control: per-instruction timelines vs. DUT outputs.
module tb_accumulator_control;
    import acc_ctrl_pkg::*;

    logic        CLK = 1'b0;
    logic        reset;
    logic [15:0] Instr;
    logic        Zero;
    logic        IRWrite, PCWrite, Branch, bneOrbeq, MemData, MemWrite, AccWrite, SpWrite;
    logic        halted;
    logic [1:0]  PCSrc, MemAddr, ALUSrcA;
    logic [2:0]  ALUSrcB, ALUOp;
    logic [3:0]  state;

    int tests = 0;
    int fails = 0;

    accumulator_control dut (
        .CLK      (CLK),
        .reset    (reset),
        .Instr    (Instr),
        .Zero     (Zero),
        .IRWrite  (IRWrite),
        .PCWrite  (PCWrite),
        .Branch   (Branch),
        .bneOrbeq (bneOrbeq),
        .PCSrc    (PCSrc),
        .MemAddr  (MemAddr),
        .MemData  (MemData),
        .MemWrite (MemWrite),
        .AccWrite (AccWrite),
        .SpWrite  (SpWrite),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .ALUOp    (ALUOp),
        .halted   (halted),
        .state    (state)
    );

    always #5 CLK = ~CLK;

    logic [24:0] obs;
    assign obs = {state, IRWrite, PCWrite, Branch, bneOrbeq, PCSrc, MemAddr, MemData,
                  MemWrite, AccWrite, SpWrite, ALUSrcA, ALUSrcB, ALUOp, halted};

    function automatic logic [24:0] mk(input logic [3:0] st, input logic ir, input logic pcw,
                                       input logic br, input logic bne, input logic [1:0] pcs,
                                       input logic [1:0] ma, input logic md, input logic mw,
                                       input logic aw, input logic sw, input logic [1:0] sa,
                                       input logic [2:0] sb, input logic [2:0] aop,
                                       input logic h);
        return {st, ir, pcw, br, bne, pcs, ma, md, mw, aw, sw, sa, sb, aop, h};
    endfunction

    // Cycles from FETCH back to FETCH; 0 means the instruction never returns (HALT).
    function automatic int latency(input logic [3:0] op);
        case (op)
            4'h0:                      return 0;
            4'h1, 4'h3, 4'h4, 4'h5, 4'h6: return 5;
            4'h2:                      return 4;
            4'h7, 4'h8, 4'h9, 4'hA, 4'hB: return 3;
            default:                   return 2;
        endcase
    endfunction

    // Expected control vector k cycles after FETCH for an instruction with opcode op.
    function automatic logic [24:0] model(input logic [3:0] op, input int k);
        logic [2:0] wb_op;
        case (op)
            4'h3:    wb_op = 3'd0;
            4'h4:    wb_op = 3'd1;
            4'h5:    wb_op = 3'd2;
            4'h6:    wb_op = 3'd3;
            default: wb_op = 3'd4;
        endcase
        if (k == 0) return mk(StFetch, 0, 1, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 2'd0, 3'd4, 3'd0, 0);
        if (k == 1) return mk(StDecode, 1, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 2'd0, 3'd0, 3'd0, 0);
        if (op == 4'h0) return mk(StHalt, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 2'd0, 3'd0, 3'd0, 1);
        if (k == 2 && op >= 4'h1 && op <= 4'h6)
            return mk(StAddr, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 2'd0, 3'd2, 3'd4, 0);
        if (k == 3 && op == 4'h2)
            return mk(StMemwr, 0, 0, 0, 0, 2'd0, 2'd2, 0, 1, 0, 0, 2'd0, 3'd0, 3'd0, 0);
        if (k == 3) return mk(StMemrd, 0, 0, 0, 0, 2'd0, 2'd2, 0, 0, 0, 0, 2'd0, 3'd0, 3'd0, 0);
        if (k == 4) return mk(StAccwb, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 1, 0, 2'd1, 3'd0, wb_op, 0);
        case (op)
            4'h7: return mk(StAcci, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 1, 0, 2'd1, 3'd1, 3'd0, 0);
            4'h8, 4'h9:
                return mk(StBr, 0, 0, 1, op[0], 2'd1, 2'd0, 0, 0, 0, 0, 2'd1, 3'd0, 3'd5, 0);
            4'hA: return mk(StJmp, 0, 1, 0, 0, 2'd1, 2'd0, 0, 0, 0, 0, 2'd0, 3'd0, 3'd0, 0);
            default:
                return mk(StSpadd, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 1, 2'd2, 3'd1, 3'd0, 0);
        endcase
    endfunction

    task automatic check(input string tag, input logic [24:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
        tests++;
        assert ($countones({MemWrite, AccWrite, SpWrite}) <= 1 && !(PCWrite && Branch)) else begin
            fails++;
            $error("FAIL %s_excl: observed mw/aw/sw/pcw/br=%b%b%b%b%b expected exclusive",
                   tag, MemWrite, AccWrite, SpWrite, PCWrite, Branch);
        end
    endtask

    // Entered just after a falling edge with the DUT in FETCH; leaves at a falling edge.
    task automatic run_instr(input logic [15:0] ins);
        int n;
        n = latency(ins[15:12]);
        Instr = ins;
        for (int k = 0; k < n; k++) begin
            Zero = 1'($urandom);
            #1;
            check($sformatf("i%h_k%0d", ins, k), model(ins[15:12], k));
            @(posedge CLK);
            @(negedge CLK);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] op;
        reset = 1'b1;
        Instr = 16'h1005;
        Zero  = 1'b0;
        @(negedge CLK); #1 check("reset_c0", '0);
        @(negedge CLK); #1 check("reset_c1", '0);
        @(negedge CLK);
        reset = 1'b0;

        run_instr(16'h1005);
        run_instr(16'h2010);
        run_instr(16'h8003);
        run_instr(16'h9003);
        run_instr(16'h7FFF);
        run_instr(16'hB002);
        run_instr(16'hE000);

        repeat (40) begin
            op = 4'($urandom_range(1, 15));
            run_instr({op, 12'($urandom)});
        end

        // Reset landing in MEMWR must suppress the write.
        Instr = 16'h2010;
        for (int k = 0; k < 3; k++) begin
            #1 check($sformatf("st_rst_k%0d", k), model(4'h2, k));
            @(posedge CLK);
            @(negedge CLK);
        end
        reset = 1'b1;
        #1 check("st_rst_memwr", '0);
        @(posedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        run_instr(16'h3001);

        // HALT holds until reset, then FETCH resumes.
        Instr = 16'h0000;
        for (int k = 0; k < 22; k++) begin
            #1 check($sformatf("halt_k%0d", k), model(4'h0, k));
            @(posedge CLK);
            @(negedge CLK);
        end
        reset = 1'b1;
        #1 check("halt_rst", '0);
        @(posedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        run_instr(16'h4002);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/accumulator_control.md
Name: accumulator_control

Overview:
- Multicycle control FSM directly upstream of the accumulator datapath top.
- Generates every datapath control input each cycle: PC write/branch, memory address/data select and write, ACC/SP write, ALU source and operation selects.
- Takes the fetched instruction word from datapath memory output and the ALU Zero flag.
- The top zero-extends each narrow select output to the datapath's 16-bit control ports.

Parameters:
- OPW, 4, opcode width (Instr[15:12])
- SW, 4, state register width

Ports:
- CLK  input  1  system clock, all state changes on rising edge
- reset  input  1  synchronous, active-high; sampled on CLK rising edge
- Instr  input  16  memory data output; valid during DECODE
- Zero  input  1  ALU zero flag (combinational, same cycle)
- IRWrite  output  1  datapath instruction latch enable
- PCWrite  output  1  unconditional PC write
- Branch  output  1  conditional PC write enable
- bneOrbeq  output  1  0=BEQ (take if Zero), 1=BNE (take if !Zero)
- PCSrc  output  2  0=aluResult, 1=ZE, 2=aluOut
- MemAddr  output  2  0=PC, 1=SELeft, 2=ALUOut
- MemData  output  1  0=ACC, 1=ALUOut
- MemWrite  output  1  memory write enable
- AccWrite  output  1  ACC write enable
- SpWrite  output  1  SP write enable
- ALUSrcA  output  2  0=PC, 1=ACC, 2=SP
- ALUSrcB  output  3  0=MDR, 1=SE, 2=ZE, 3=SL1, 4=constant 2
- ALUOp  output  3  0=ADD, 1=SUB, 2=AND, 3=OR, 4=PASSB, 5=PASSA
- halted  output  1  high in HALT state
- state  output  4  current state (debug)

Behaviour:
- Outputs are Moore: a function of state_q and latched opcode op_q only. Instr is used only to load op_q.
- Any output not listed for a state is 0.
- Reset:
  - While reset is high, all outputs are forced to 0, including halted.
  - At the clock edge with reset high: state_q<=FETCH, op_q<=0.
  - Reset mid-instruction abandons the instruction; no write occurs in the reset cycle.
- Opcodes:
  - 0 HALT, 1 LOAD, 2 STORE, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 ADDI, 8 BEQ, 9 BNE, A JUMP, B ADDSP.
  - C-F are illegal and execute as a NOP (DECODE->FETCH).
- States and outputs:
  - FETCH: MemAddr=0, ALUSrcA=0, ALUSrcB=4, ALUOp=ADD, PCSrc=0, PCWrite=1. Next: DECODE.
  - DECODE: IRWrite=1; op_q<=Instr[15:12]. Next by opcode:
    - 0 -> HALT
    - 1,3-6 -> ADDR
    - 2 -> ADDR
    - 7 -> ACCI
    - 8,9 -> BR
    - A -> JMP
    - B -> SPADD
    - illegal -> FETCH
  - ADDR: ALUSrcB=2, ALUOp=PASSB (aluOut<=ZE). Next: MEMWR if op_q=STORE, else MEMRD.
  - MEMRD: MemAddr=2. Next: ACCWB.
  - ACCWB: ALUSrcA=1, ALUSrcB=0, AccWrite=1. ALUOp is PASSB for LOAD, ADD/SUB/AND/OR for opcodes 3/4/5/6. Next: FETCH.
  - MEMWR: MemAddr=2, MemData=0, MemWrite=1. Next: FETCH.
  - ACCI: ALUSrcA=1, ALUSrcB=1, ALUOp=ADD, AccWrite=1. Next: FETCH.
  - BR: ALUSrcA=1, ALUOp=PASSA, Branch=1, bneOrbeq=op_q[0], PCSrc=1. Next: FETCH. The take/not-take decision uses Zero in this cycle and is applied by the PC unit.
  - JMP: PCSrc=1, PCWrite=1. Next: FETCH.
  - SPADD: ALUSrcA=2, ALUSrcB=1, ALUOp=ADD, SpWrite=1. Next: FETCH.
  - HALT: halted=1, all enables 0. Stays in HALT until reset.
- Latency in cycles, FETCH to next FETCH:
  - LOAD/ADD/SUB/AND/OR: 5
  - STORE: 4
  - ADDI/BEQ/BNE/JUMP/ADDSP: 3
  - illegal: 2
- Exclusivity: at most one of MemWrite, AccWrite, SpWrite is high in any cycle. PCWrite and Branch are never both high.
- Unused state encodings go to FETCH on the next edge.

Decomposition:
- Package acc_ctrl_pkg: opcode constants, state enum (FETCH, DECODE, ADDR, MEMRD, ACCWB, MEMWR, ACCI, BR, JMP, SPADD, HALT), PCSrc/MemAddr/MemData/ALUSrcA/ALUSrcB/ALUOp encodings.
- Sub-module acc_ctrl_outputs: pure combinational (state_q, op_q) -> control vector, including the reset gating.
- Top holds state_q, op_q and the next-state logic.

Test Plan:
- Reset for 2 cycles, release, Instr=0x1005 (LOAD):
  - all outputs are 0 during reset
  - states FETCH, DECODE, ADDR, MEMRD, ACCWB, then FETCH
  - AccWrite=1 with ALUOp=4 only in cycle 5
- Instr=0x2010 (STORE): 4-cycle sequence; MemWrite=1, MemAddr=2, MemData=0 exactly once, in MEMWR.
- Instr=0x8003 (BEQ) and 0x9003 (BNE): in BR, Branch=1, PCSrc=1, PCWrite=0; bneOrbeq is 0 and 1 respectively.
- Instr=0x7FFF (ADDI) then 0xB002 (ADDSP) then 0xE000 (illegal):
  - ADDI and ADDSP each take 3 cycles
  - AccWrite, then SpWrite, pulse once each
  - illegal returns to FETCH after DECODE with no write enables asserted
- Instr=0x0000 (HALT): halted=1 held for 20 cycles with all enables 0. Assert reset: next edge reaches FETCH and halted drops to 0.
- Assert reset during MEMWR of a STORE: MemWrite=0 in the reset cycle; FETCH follows deassertion.
